// File: rtl/fifo_rd_drain.sv
// Read-side drain stage for an async FIFO: reads only when a word is present and
// skid space is guaranteed. Optional FIFO_RD_DRAIN_CNT_EN adds the rd_count port.
module fifo_rd_drain #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic             drain_en,
  input  logic             empty,
  input  logic             underflow,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       state,
  output logic             err_underflow
`ifdef FIFO_RD_DRAIN_CNT_EN
  ,
  output logic [15:0]      rd_count
`endif
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             inflight;
  logic [OCC_W-1:0] occ, occ_d;
  logic [WIDTH-1:0] skid_q [DEPTH];
  logic [WIDTH-1:0] skid_d [DEPTH];
  logic             push, pop;

  // Budget counts the word already requested from the FIFO so the buffer cannot overflow
  assign rd_en   = (state_q == RUN) && !empty &&
                   ((3'(occ) + 3'(inflight)) < 3'(DEPTH));
  assign push    = inflight;
  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = skid_q[0];
  assign state   = state_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      inflight <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drain_en) state_d = RUN;
      RUN:     if (!drain_en) state_d = STOP;
      STOP:    if (!inflight) state_d = drain_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head-at-index-0 shift buffer: pop shifts down, push lands after the survivors
  always_comb begin
    skid_d = skid_q;
    occ_d  = occ;
    if (pop) begin
      skid_d[0] = skid_q[1];
      skid_d[1] = skid_q[2];
      occ_d     = occ - OCC_W'(1);
    end
    if (push) begin
      skid_d[occ_d] = rdata;
      occ_d         = occ_d + OCC_W'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) skid_q[i] <= '0;
    end else begin
      occ    <= occ_d;
      skid_q <= skid_d;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) err_underflow <= 1'b0;
    else if (underflow) err_underflow <= 1'b1;
  end

`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [15:0] rd_count_r;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) rd_count_r <= '0;
    else if (pop) rd_count_r <= rd_count_r + 16'd1;
  end

  assign rd_count = rd_count_r;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural read-side FIFO model.
module tb_fifo_rd_drain;

  logic       rd_clk = 1'b0;
  logic       rst_n, drain_en, underflow, m_ready, force_empty;
  logic       empty, rd_en, m_valid, err_underflow;
  logic [7:0] rdata, m_data;
  logic [1:0] state;
`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [15:0] rd_count;
`endif

  logic [7:0] mem [64];
  int         wr_ptr, rd_ptr = 0;
  int         rd_pulses = 0, got_n = 0, cyc = 0;
  logic [7:0] got [64];
  int         got_t [64];
  int         checks = 0, errors = 0;
  int         base_g, base_r, bad, vbad;
  logic       reached;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.WIDTH(8)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .drain_en(drain_en), .empty(empty),
    .underflow(underflow), .rdata(rdata), .rd_en(rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .state(state), .err_underflow(err_underflow)
`ifdef FIFO_RD_DRAIN_CNT_EN
    , .rd_count(rd_count)
`endif
  );

  // FIFO read side: data appears the cycle after rd_en is sampled
  assign empty = (rd_ptr == wr_ptr) || force_empty;

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rdata     <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses <= rd_pulses + 1;
    end
    if (m_valid && m_ready) begin
      got[got_n % 64]   <= m_data;
      got_t[got_n % 64] <= cyc;
      got_n             <= got_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
  endtask

  initial begin
    rst_n = 1'b0; drain_en = 1'b0; underflow = 1'b0; m_ready = 1'b0;
    force_empty = 1'b0; wr_ptr = 0;
    repeat (2) @(negedge rd_clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_occ", 32'(dut.occ), 0);
`ifdef FIFO_RD_DRAIN_CNT_EN
    chk("rst_rd_count", 32'(rd_count), 0);
`endif
    rst_n = 1'b1;
    @(negedge rd_clk);

    // basic stream
    base_g = got_n; base_r = rd_pulses;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    m_ready = 1'b1; drain_en = 1'b1;
    repeat (10) @(negedge rd_clk);
    chk("basic_reads", 32'(rd_pulses - base_r), 3);
    chk("basic_count", 32'(got_n - base_g), 3);
    chk("basic_w0", 32'(got[base_g]), 32'h11);
    chk("basic_w1", 32'(got[base_g + 1]), 32'h22);
    chk("basic_w2", 32'(got[base_g + 2]), 32'h33);
    chk("basic_back_to_back", 32'(got_t[base_g + 2] - got_t[base_g]), 2);
    chk("basic_rd_en_empty", 32'(rd_en), 0);
`ifdef FIFO_RD_DRAIN_CNT_EN
    chk("basic_rd_count", 32'(rd_count), 3);
`endif

    // backpressure
    m_ready = 1'b0; base_g = got_n; base_r = rd_pulses; bad = 0;
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    repeat (10) begin
      @(negedge rd_clk);
      if (m_valid && m_data !== 8'hA0) bad++;
    end
    chk("bp_reads", 32'(rd_pulses - base_r), 3);
    chk("bp_occ", 32'(dut.occ), 3);
    chk("bp_head", 32'(m_data), 32'hA0);
    chk("bp_stable", 32'(bad), 0);
    m_ready = 1'b1;
    repeat (14) @(negedge rd_clk);
    chk("bp_count", 32'(got_n - base_g), 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (got[base_g + i] !== 8'hA0 + 8'(i)) bad++;
    chk("bp_order", 32'(bad), 0);
    chk("bp_rate", 32'(got_t[base_g + 7] - got_t[base_g]), 7);

    // stop with a word in flight
    base_g = got_n; base_r = rd_pulses;
    push_word(8'h5C); drain_en = 1'b0;
    #1 chk("stop_rd_en_last", 32'(rd_en), 1);
    @(negedge rd_clk);
    chk("stop_state", 32'(state), 2);
    chk("stop_no_rd_en", 32'(rd_en), 0);
    repeat (4) @(negedge rd_clk);
    chk("stop_idle", 32'(state), 0);
    chk("stop_delivered", 32'(got_n - base_g), 1);
    chk("stop_word", 32'(got[base_g]), 32'h5C);
    push_word(8'h77);
    repeat (5) @(negedge rd_clk);
    chk("stop_no_more_reads", 32'(rd_pulses - base_r), 1);

    // empty FIFO
    force_empty = 1'b1; drain_en = 1'b1; base_r = rd_pulses; bad = 0; vbad = 0;
    repeat (20) begin
      @(negedge rd_clk);
      if (rd_en) bad++;
      if (m_valid) vbad++;
    end
    chk("empty_rd_en", 32'(bad), 0);
    chk("empty_m_valid", 32'(vbad), 0);
    chk("empty_reads", 32'(rd_pulses - base_r), 0);
    chk("empty_err", 32'(err_underflow), 0);
    chk("empty_run", 32'(state), 1);
    base_g = got_n; force_empty = 1'b0;
    repeat (5) @(negedge rd_clk);
    chk("resume_word", 32'(got[base_g]), 32'h77);

    // underflow flag
    underflow = 1'b1;
    @(negedge rd_clk);
    underflow = 1'b0;
    chk("uf_set", 32'(err_underflow), 1);
    repeat (5) @(negedge rd_clk);
    chk("uf_sticky", 32'(err_underflow), 1);

    // reset mid-stream with occ=2, inflight=1
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'hB0 + 8'(i));
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge rd_clk);
      if (dut.occ == 2'd2 && dut.inflight) reached = 1'b1;
    end
    chk("mid_reached", 32'(reached), 1);
    chk("mid_read_blocked", 32'(rd_en), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_m_data", 32'(m_data), 0);
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_err", 32'(err_underflow), 0);
    chk("mid_rst_inflight", 32'(dut.inflight), 0);
    drain_en = 1'b0;
    @(negedge rd_clk);
    rst_n = 1'b1; m_ready = 1'b1; base_g = got_n;
    repeat (4) @(negedge rd_clk);
    chk("mid_no_stale", 32'(got_n - base_g), 0);
    chk("mid_no_valid", 32'(m_valid), 0);
    m_ready = 1'b0; drain_en = 1'b1;
    repeat (6) @(negedge rd_clk);
    chk("mid_head_next", 32'(m_data), 32'hB3);
    chk("mid_occ", 32'(dut.occ), 2);
`ifdef FIFO_RD_DRAIN_CNT_EN
    force dut.rd_count_r = 16'hFFFF;
    #1 release dut.rd_count_r;
`endif
    m_ready = 1'b1;
    @(negedge rd_clk);
    m_ready = 1'b0;
    chk("pop_one", 32'(m_data), 32'hB4);
`ifdef FIFO_RD_DRAIN_CNT_EN
    chk("count_wrap", 32'(rd_count), 0);
`endif
    @(negedge rd_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage sitting directly downstream of the asynchronous FIFO, in the `rd_clk` domain. Watches the FIFO's `empty` flag, issues `rd_en` only when a word is available and buffer space is guaranteed, captures `rdata` one cycle later, and presents the words on a valid/ready master stream through a 3-entry skid buffer. It never drives a read into an empty FIFO, so FIFO underflow is impossible by construction; any observed `underflow` is latched as an error.

## Interface
- `WIDTH`, default 8: data width; must equal the FIFO data width.
- `rd_clk` input 1: FIFO read-domain clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `drain_en` input 1: enables reading from the FIFO.
- `empty` input 1: FIFO empty flag (synchronous to `rd_clk`).
- `underflow` input 1: FIFO underflow flag.
- `rdata` input WIDTH: FIFO read data, valid the cycle after `rd_en` is sampled high.
- `rd_en` output 1: FIFO read strobe, driven from registered state only.
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: stream consumer ready.
- `m_data` output WIDTH: stream data, the head of the skid buffer.
- `state` output 2: 0 IDLE, 1 RUN, 2 STOP.
- `err_underflow` output 1: sticky underflow error.
- `rd_count` output 16: delivered-word counter. Present only with `FIFO_RD_DRAIN_CNT_EN`.

## Operation
- `occ` is the number of words in the skid buffer (0..3). `inflight` is 1 if `rd_en` was high in the previous cycle.
- `rd_en = (state==RUN) && !empty && (occ + inflight) < 3`. There is no combinational path from `m_ready` or `drain_en` to `rd_en`; both are registered into `state` first.
- Capture: in the cycle after `rd_en`, `rdata` is pushed to the buffer tail.
- Output: `m_valid = (occ != 0)`. `m_data` is the head word.
- Pop: a pop occurs on `m_valid && m_ready`. A push and a pop in the same cycle leave `occ` unchanged.
- Words leave in FIFO order. None are dropped or duplicated.
- State machine:
  - IDLE → RUN when `drain_en`=1.
  - RUN → STOP when `drain_en`=0.
  - STOP: `rd_en` is 0. The in-flight word, if any, is still captured. STOP → IDLE when `inflight`=0; the buffer keeps draining to the stream in any state.
  - STOP → RUN when `drain_en`=1 with `inflight`=0. Otherwise the block waits in STOP.
- `err_underflow` is set on any cycle where `underflow`=1. It is cleared only by reset.
- Boundary conditions:
  - With `occ`=3 and `m_ready`=0, no reads are issued.
  - With `occ`=2 and `inflight`=1, no reads are issued. This guarantees the buffer never overflows.
  - `empty` asserting in the same cycle as a capture has no effect on that capture.

## Timing
- Reset values: `rd_en` 0, `m_valid` 0, `m_data` 0, `state` IDLE, `err_underflow` 0, `rd_count` 0, `occ` 0, `inflight` 0.
- Reset mid-operation clears all state immediately. The in-flight FIFO word is discarded.
- Latency from `drain_en` rising to the first `rd_en` is 1 cycle (state register).
- Latency from `rd_en` to `m_valid` is 2 cycles: capture edge, then buffer output.
- Sustained throughput is 1 word per cycle with `m_ready`=1 and `empty`=0.
- `m_data` is held stable while `m_valid`=1 and `m_ready`=0.

## Configuration
- `FIFO_RD_DRAIN_CNT_EN` defined: the `rd_count` port exists. It is a 16-bit count of stream handshakes, incremented on each pop, wrapping from 0xFFFF to 0, reset to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Basic stream:** reset, then `drain_en`=1, FIFO holds 0x11,0x22,0x33, `m_ready`=1. Required: three `rd_en` pulses, then `m_data` 0x11,0x22,0x33 on consecutive `m_valid` cycles. `rd_en` stays 0 once `empty`=1. `rd_count`=3.
- **Backpressure:** FIFO holds 8 words, `m_ready`=0 for 10 cycles. Required: exactly 3 reads, `occ`=3, `m_data` stable at word 0. After `m_ready`=1, all 8 words arrive in order at 1/cycle after refill.
- **Stop with word in flight:** drop `drain_en` the cycle `rd_en`=1. Required: `state` STOP, the word is still delivered, then `state` IDLE, and no further `rd_en`.
- **Empty FIFO:** `drain_en`=1, `empty`=1 for 20 cycles. Required: `rd_en`=0 throughout, `m_valid`=0, `err_underflow`=0.
- **Underflow flag:** pulse `underflow`=1 for 1 cycle. Required: `err_underflow`=1 from the next cycle until `rst_n` is low.
- **Reset mid-stream:** assert `rst_n`=0 with `occ`=2 and `inflight`=1. Required: all outputs take their reset values immediately, and after release no stale word appears. With the macro, also pre-load `rd_count`=0xFFFF and perform 1 pop; required: `rd_count`=0.
